// File: rtl/sound_pkg.sv
// Shared constants for the noise channel control path: register offsets, frame timing, volume limits.
// Latency: none (constants only).
// Backpressure: none (constants only).
package sound_pkg;

    // Register offsets on the 2-bit write address
    localparam logic [1:0] NR41 = 2'd0;
    localparam logic [1:0] NR42 = 2'd1;
    localparam logic [1:0] NR43 = 2'd2;
    localparam logic [1:0] NR44 = 2'd3;

    // 4194304 Hz system clock divided down to the 512 Hz frame sequencer
    localparam int CLK_DIV_DEFAULT = 8192;

    // Bit s set means frame step s clocks the length counter (steps 0, 2, 4, 6)
    localparam logic [7:0] LEN_STEPS = 8'b0101_0101;

    // Frame step that clocks the volume envelope
    localparam logic [2:0] ENV_STEP = 3'd7;

    // Envelope volume saturates at these limits
    localparam logic [3:0] VOL_MIN = 4'd0;
    localparam logic [3:0] VOL_MAX = 4'd15;

    // Envelope timer reload value; a period of 0 loads 8 on trigger
    function automatic logic [3:0] envReload(input logic [2:0] period);
        return (period == 3'd0) ? 4'd8 : {1'b0, period};
    endfunction

endpackage

// File: rtl/noise_sequencer_if.sv
// CPU-facing byte write port into the noise channel register file.
// Latency: none (wires only).
// Backpressure: none; every strobed write is accepted.
interface noise_sequencer_if;

    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/envelope_unit.sv
// Volume envelope: loads start volume on trigger, steps it up/down on envelope ticks, saturating.
// Latency: trigger or envelope tick -> volume, 1 cycle.
// Backpressure: none; every trigger and tick is consumed on the cycle it arrives.
module envelope_unit
    import sound_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic       step7Tick,
    input  logic [3:0] startVol,
    input  logic       envAdd,
    input  logic [2:0] envPeriod,
    output logic [3:0] volume
);

    logic [3:0] envTimer;
    logic       envActive;
    logic       envStep;
    logic       atLimit;

    // An envelope tick only counts when a period is programmed and the envelope is still running
    assign envStep = step7Tick && (envPeriod != 3'd0) && envActive;

    // Volume cannot move further in the programmed direction
    assign atLimit = envAdd ? (volume == VOL_MAX) : (volume == VOL_MIN);

    // Trigger reload takes priority over an envelope step landing on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            volume    <= 4'd0;
            envTimer  <= 4'd0;
            envActive <= 1'b0;
        end else if (trigger) begin
            volume    <= startVol;
            envTimer  <= envReload(envPeriod);
            envActive <= 1'b1;
        end else if (envStep) begin
            if (envTimer > 4'd1) begin
                envTimer <= envTimer - 4'd1;
            end else begin
                envTimer <= {1'b0, envPeriod};
                if (atLimit) begin
                    envActive <= 1'b0;
                end else if (envAdd) begin
                    volume <= volume + 4'd1;
                end else begin
                    volume <= volume - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/noise_sequencer.sv
// Noise channel control: NR41-NR44 register file, 512 Hz frame sequencer, length strobe, envelope.
// Latency: write -> field/trigger/volume 1 cycle; frame tick -> len_clk 1 cycle.
// Backpressure: none; writes are accepted every cycle, ticks never stall.
module noise_sequencer
    import sound_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int DIV_W   = 13
) (
    input  logic               clk,
    input  logic               reset,
    noise_sequencer_if.slave   wrBus,
    output logic [5:0]         len_load,
    output logic [3:0]         start_vol,
    output logic               env_add,
    output logic [2:0]         env_period,
    output logic [3:0]         clk_shift,
    output logic               width_mode,
    output logic [2:0]         divisor,
    output logic               len_enable,
    output logic               trigger,
    output logic               len_clk,
    output logic [3:0]         volume,
    output logic [2:0]         frame_step
);

    logic [DIV_W-1:0] divCnt;
    logic             tick;
    logic             wrNr41;
    logic             wrNr42;
    logic             wrNr43;
    logic             wrNr44;
    logic             trigEvt;
    logic             step7Tick;

    // Tick on the last count of each divider period
    assign tick = (divCnt == DIV_W'(CLK_DIV - 1));

    // Register write decode; a trigger is an NR44 write with bit 7 set
    always_comb begin
        wrNr41  = wrBus.wr_en && (wrBus.wr_addr == NR41);
        wrNr42  = wrBus.wr_en && (wrBus.wr_addr == NR42);
        wrNr43  = wrBus.wr_en && (wrBus.wr_addr == NR43);
        wrNr44  = wrBus.wr_en && (wrBus.wr_addr == NR44);
        trigEvt = wrNr44 && wrBus.wr_data[7];
    end

    // Free-running divider from system clock down to the frame-sequencer rate
    always_ff @(posedge clk) begin
        if (reset) begin
            divCnt <= '0;
        end else if (tick) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + DIV_W'(1);
        end
    end

    // Execute the pending frame step on each tick; even steps strobe the length counter next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_step <= 3'd0;
            len_clk    <= 1'b0;
        end else begin
            len_clk <= tick && LEN_STEPS[frame_step];
            if (tick) begin
                frame_step <= frame_step + 3'd1;
            end
        end
    end

    // Register file; unused bits of NR41/NR44 and the NR44 trigger bit are not stored
    always_ff @(posedge clk) begin
        if (reset) begin
            len_load   <= 6'd0;
            start_vol  <= 4'd0;
            env_add    <= 1'b0;
            env_period <= 3'd0;
            clk_shift  <= 4'd0;
            width_mode <= 1'b0;
            divisor    <= 3'd0;
            len_enable <= 1'b0;
        end else begin
            if (wrNr41) begin
                len_load <= wrBus.wr_data[5:0];
            end
            if (wrNr42) begin
                start_vol  <= wrBus.wr_data[7:4];
                env_add    <= wrBus.wr_data[3];
                env_period <= wrBus.wr_data[2:0];
            end
            if (wrNr43) begin
                clk_shift  <= wrBus.wr_data[7:4];
                width_mode <= wrBus.wr_data[3];
                divisor    <= wrBus.wr_data[2:0];
            end
            if (wrNr44) begin
                len_enable <= wrBus.wr_data[6];
            end
        end
    end

    // One-cycle trigger pulse following each triggering NR44 write
    always_ff @(posedge clk) begin
        if (reset) begin
            trigger <= 1'b0;
        end else begin
            trigger <= trigEvt;
        end
    end

    // Envelope is clocked by the tick that executes the envelope step
    assign step7Tick = tick && (frame_step == ENV_STEP);

    envelope_unit u_envelope (
        .clk       (clk),
        .reset     (reset),
        .trigger   (trigEvt),
        .step7Tick (step7Tick),
        .startVol  (start_vol),
        .envAdd    (env_add),
        .envPeriod (env_period),
        .volume    (volume)
    );

endmodule

// File: tb/tb_noise_sequencer.sv
// Bench for noise_sequencer: directed scenarios plus random register traffic against a timeline model.
// Latency: model predicts every output one edge after the inputs it sees.
// Backpressure: none.
module tb_noise_sequencer;

    localparam int CD = 4;

    logic       clk;
    logic       reset;
    logic [5:0] len_load;
    logic [3:0] start_vol;
    logic       env_add;
    logic [2:0] env_period;
    logic [3:0] clk_shift;
    logic       width_mode;
    logic [2:0] divisor;
    logic       len_enable;
    logic       trigger;
    logic       len_clk;
    logic [3:0] volume;
    logic [2:0] frame_step;

    noise_sequencer_if busIf ();

    noise_sequencer #(.CLK_DIV(CD), .DIV_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .wrBus      (busIf),
        .len_load   (len_load),
        .start_vol  (start_vol),
        .env_add    (env_add),
        .env_period (env_period),
        .clk_shift  (clk_shift),
        .width_mode (width_mode),
        .divisor    (divisor),
        .len_enable (len_enable),
        .trigger    (trigger),
        .len_clk    (len_clk),
        .volume     (volume),
        .frame_step (frame_step)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nPass  = 0;
    int nTotal = 0;

    // Model state: cyc counts clock edges since reset was released
    int cyc = 0;
    int mLen, mSv, mAdd, mPer, mShift, mWidth, mDiv, mLenEn;
    int mTrig, mLenClk, mVol, mTimer, mActive, mStep;

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        nTotal++;
        assert (obs === 32'(expv)) nPass++;
        else $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, expv, $time);
    endtask

    task automatic modelReset();
        cyc = 0;
        mLen = 0; mSv = 0; mAdd = 0; mPer = 0; mShift = 0; mWidth = 0; mDiv = 0; mLenEn = 0;
        mTrig = 0; mLenClk = 0; mVol = 0; mTimer = 0; mActive = 0; mStep = 0;
    endtask

    // One rising edge of the model, working from elapsed time rather than DUT state
    task automatic modelEdge(input bit we, input logic [1:0] a, input logic [7:0] d);
        bit tick;
        int s;
        bit trig;
        int target;
        tick = ((cyc % CD) == CD - 1);
        s    = (cyc / CD) % 8;
        trig = we && (a == 2'd3) && d[7];
        if (trig) begin
            mVol    = mSv;
            mTimer  = (mPer == 0) ? 8 : mPer;
            mActive = 1;
        end else if (tick && s == 7 && mPer != 0 && mActive != 0) begin
            if (mTimer > 1) begin
                mTimer = mTimer - 1;
            end else begin
                mTimer = mPer;
                target = (mAdd != 0) ? mVol + 1 : mVol - 1;
                if (target >= 0 && target <= 15) mVol = target;
                else mActive = 0;
            end
        end
        mTrig   = trig ? 1 : 0;
        mLenClk = (tick && (s % 2 == 0)) ? 1 : 0;
        if (we) begin
            case (a)
                2'd0: mLen = int'(d[5:0]);
                2'd1: begin mSv = int'(d[7:4]); mAdd = int'(d[3]); mPer = int'(d[2:0]); end
                2'd2: begin mShift = int'(d[7:4]); mWidth = int'(d[3]); mDiv = int'(d[2:0]); end
                default: mLenEn = int'(d[6]);
            endcase
        end
        cyc   = cyc + 1;
        mStep = (cyc / CD) % 8;
    endtask

    task automatic checkAll();
        chk("len_load",   32'(len_load),   mLen);
        chk("start_vol",  32'(start_vol),  mSv);
        chk("env_add",    32'(env_add),    mAdd);
        chk("env_period", 32'(env_period), mPer);
        chk("clk_shift",  32'(clk_shift),  mShift);
        chk("width_mode", 32'(width_mode), mWidth);
        chk("divisor",    32'(divisor),    mDiv);
        chk("len_enable", 32'(len_enable), mLenEn);
        chk("trigger",    32'(trigger),    mTrig);
        chk("len_clk",    32'(len_clk),    mLenClk);
        chk("volume",     32'(volume),     mVol);
        chk("frame_step", 32'(frame_step), mStep);
    endtask

    // Drive inputs for one cycle, advance the model on the edge, check on the falling edge
    task automatic step(input bit rst, input bit we, input logic [1:0] a, input logic [7:0] d);
        reset         = rst;
        busIf.wr_en   = we;
        busIf.wr_addr = a;
        busIf.wr_data = d;
        @(posedge clk);
        if (rst) modelReset();
        else modelEdge(we, a, d);
        @(negedge clk);
        busIf.wr_en = 1'b0;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, a, d);
    endtask

    // Idle until the next edge is the tick that executes step 7
    task automatic alignStep7();
        for (int k = 0; k < 32 && (cyc % 32) != 31; k++) idle(1);
    endtask

    initial begin
        int pulses;
        int lastPulse;
        bit rst;
        bit we;
        logic [1:0] a;
        logic [7:0] d;

        reset = 1'b1;
        busIf.wr_en = 1'b0;
        busIf.wr_addr = 2'd0;
        busIf.wr_data = 8'h00;
        modelReset();

        // Reset state, including a write presented during reset
        step(1'b1, 1'b0, 2'd0, 8'h00);
        step(1'b1, 1'b1, 2'd1, 8'hFF);
        step(1'b1, 1'b1, 2'd3, 8'hC0);
        chk("reset_volume", 32'(volume), 0);
        chk("reset_trigger", 32'(trigger), 0);

        // Idle 100 cycles: length strobes every 8 cycles
        pulses = 0;
        lastPulse = -1;
        for (int i = 0; i < 100; i++) begin
            idle(1);
            if (len_clk === 1'b1) begin
                if (lastPulse >= 0) chk("len_spacing", 32'(cyc - lastPulse), 8);
                lastPulse = cyc;
                pulses++;
            end
        end
        chk("len_pulse_count", 32'(pulses), 13);

        // Field decode, each visible one cycle after its write
        wr(2'd1, 8'hA3);
        chk("nr42_start_vol", 32'(start_vol), 10);
        chk("nr42_env_add", 32'(env_add), 0);
        chk("nr42_period", 32'(env_period), 3);
        wr(2'd2, 8'h5B);
        chk("nr43_shift", 32'(clk_shift), 5);
        chk("nr43_width", 32'(width_mode), 1);
        chk("nr43_divisor", 32'(divisor), 3);
        wr(2'd0, 8'hFF);
        chk("nr41_len_load", 32'(len_load), 63);

        // Trigger pulse and length enable
        wr(2'd3, 8'hC0);
        chk("trig_pulse", 32'(trigger), 1);
        chk("trig_len_en", 32'(len_enable), 1);
        chk("trig_volume", 32'(volume), 10);
        idle(1);
        chk("trig_one_cycle", 32'(trigger), 0);
        wr(2'd3, 8'h40);
        chk("no_trig_pulse", 32'(trigger), 0);

        // Rising envelope saturates at 15
        wr(2'd1, 8'h29);
        wr(2'd3, 8'h80);
        chk("env_up_start", 32'(volume), 2);
        idle(32 * 15);
        chk("env_up_sat", 32'(volume), 15);

        // Falling envelope saturates at 0
        wr(2'd1, 8'h21);
        wr(2'd3, 8'h80);
        idle(32 * 4);
        chk("env_down_sat", 32'(volume), 0);

        // Period 0 holds volume
        wr(2'd1, 8'h70);
        wr(2'd3, 8'h80);
        idle(32 * 5);
        chk("env_period0_hold", 32'(volume), 7);

        // Trigger on the step-7 tick: load wins, no step applied
        wr(2'd1, 8'h59);
        wr(2'd3, 8'h80);
        idle(40);
        alignStep7();
        wr(2'd3, 8'h80);
        chk("trig_on_step7", 32'(volume), 5);
        idle(10);

        // Reset mid-envelope restarts the sequence
        step(1'b1, 1'b0, 2'd0, 8'h00);
        chk("midreset_volume", 32'(volume), 0);
        chk("midreset_step", 32'(frame_step), 0);
        chk("midreset_len_clk", 32'(len_clk), 0);
        idle(40);

        // Random register traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom % 500) == 0;
            we  = ($urandom % 6) == 0;
            a   = 2'($urandom);
            d   = 8'($urandom);
            step(rst, we, a, d);
        end

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/noise_sequencer.md
Name: noise_sequencer

Overview:
- Control and scheduling block for the noise channel.
- Holds the NR41–NR44 register state written over a simple byte write port and presents those fields to the noise datapath.
- Runs the 512 Hz frame sequencer that produces the length-clock strobes.
- Runs the volume envelope that produces the channel's current 4-bit volume.
- Sits between the CPU-facing register bus and the noise channel / length counter.

Parameters:
- CLK_DIV, 8192: system clocks per frame-sequencer tick (4194304 Hz / 512 Hz); must be ≥ 2.
- DIV_W, 13: width of the divider counter; must satisfy 2^DIV_W ≥ CLK_DIV.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  register write strobe, one cycle per write.
- wr_addr  in  2  register select: 0=NR41, 1=NR42, 2=NR43, 3=NR44.
- wr_data  in  8  write data.
- len_load  out  6  NR41[5:0].
- start_vol  out  4  NR42[7:4].
- env_add  out  1  NR42[3].
- env_period  out  3  NR42[2:0].
- clk_shift  out  4  NR43[7:4].
- width_mode  out  1  NR43[3].
- divisor  out  3  NR43[2:0].
- len_enable  out  1  NR44[6].
- trigger  out  1  one-cycle pulse per NR44 write with bit 7 set.
- len_clk  out  1  one-cycle length strobe, 256 Hz.
- volume  out  4  current envelope volume.
- frame_step  out  3  next frame-sequencer step to execute.

Behaviour:
- Reset:
  - All outputs are 0, including all register fields.
  - Divider is 0, frame_step is 0, env_timer is 0, env_active is 0.
  - Reset overrides writes and ticks in the same cycle.
- Register writes:
  - Fields update on the edge that samples wr_en=1 and are visible the next cycle.
  - NR41 bits [7:6] are ignored.
  - NR44 bits [5:0] are ignored.
  - NR44 bit 7 is never stored.
- Trigger:
  - An NR44 write with wr_data[7]=1 sets trigger=1 for exactly the next cycle.
  - On that same edge:
    - volume ← currently stored start_vol;
    - env_timer ← (env_period==0 ? 8 : env_period);
    - env_active ← 1.
  - An NR44 write with wr_data[7]=0 updates len_enable only.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - A tick occurs on the cycle the count equals CLK_DIV-1.
- Frame sequencer:
  - On each tick, the step s = frame_step is executed, then frame_step ← s+1 mod 8.
  - The first tick after reset executes step 0.
- Length strobe: len_clk=1 for exactly one cycle, the cycle after a tick executing an even step (0, 2, 4, 6). It is 0 at all other times.
- Envelope, on a tick executing step 7, when env_period≠0 and env_active=1:
  - If env_timer > 1: env_timer decrements.
  - Otherwise, env_timer reloads to env_period and:
    - if env_add and volume<15: volume+1;
    - else if !env_add and volume>0: volume-1;
    - else: env_active ← 0 and volume holds.
- Envelope, period 0: with env_period=0 the volume never changes; the timer holds.
- Envelope writes: an NR42 write does not alter volume, env_timer or env_active until the next trigger.
- Simultaneous events:
  - A trigger in the same cycle as a step-7 tick: trigger load wins and the envelope step is skipped.
  - A tick in the same cycle as a register write: both take effect.
- Arithmetic: volume saturates at 0 and 15 and never wraps.
- Latency: write → field, 1 cycle; write → trigger/volume, 1 cycle; tick → len_clk, 1 cycle.

Decomposition:
- Shared package sound_pkg holds:
  - register offsets NR41..NR44;
  - default CLK_DIV;
  - step constants LEN_STEPS (even) and ENV_STEP=7;
  - volume limits VOL_MIN=0 and VOL_MAX=15.
- One natural sub-module, envelope_unit, holds volume, env_timer and env_active, with inputs trigger, step7_tick, start_vol, env_add and env_period.
- Divider, frame sequencer and register file stay in the top level.

Test Plan:
- Reset, then idle 100 cycles with CLK_DIV=4 → len_clk pulses exactly every 8 cycles at steps 0,2,4,6; frame_step cycles 0..7; all register outputs 0.
- Write NR42=0xA3, NR43=0x5B, NR41=0xFF → start_vol=10, env_add=0, env_period=3, clk_shift=5, width_mode=1, divisor=3, len_load=63, each one cycle after its write.
- Write NR44=0xC0 → trigger high exactly one cycle, len_enable=1, volume=10; write NR44=0x40 → no trigger pulse.
- NR42=0x29 (vol 2, add, period 1), trigger, CLK_DIV=4 → volume 3, 4, … on successive step-7 ticks, stops at 15 and stays at 15; with add=0 from vol 2 → 1, 0, then holds at 0.
- NR42 period 0, vol 7, trigger → volume stays 7 across 5 step-7 ticks.
- Trigger written on the exact step-7 tick cycle → volume=start_vol with no envelope step applied; assert reset mid-envelope → volume, frame_step and len_clk are 0 next cycle and the sequence restarts at step 0.
